// File: rtl/saes_byte_loader.sv
// Byte-serial key/plaintext loader feeding saes_main through a small tagged FIFO.
// Define SAES_BLK_COUNT_EN to add the blk_count delivered-block counter port.
module saes_byte_loader #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_is_key,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [15:0] blk_data,
  output logic [15:0] blk_key,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        frame_err
`ifdef SAES_BLK_COUNT_EN
  ,
  output logic [15:0] blk_count
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {HI, LO} state_e;

  state_e        state_q, state_d;
  logic [7:0]    hi_q, hi_d;
  logic          kind_q, kind_d;
  logic [15:0]   key_q, key_d;
  logic          key_loaded_q, key_loaded_d;
  logic          frame_err_q, frame_err_d;
  logic          push, pop, accept, full;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [31:0]   mem_q [DEPTH];
  logic [31:0]   head;

  assign full       = (count_q == FULL_CNT);
  assign byte_ready = !full;
  assign accept     = byte_valid & byte_ready;
  assign blk_valid  = (count_q != '0);
  assign pop        = blk_valid & blk_ready;
  assign head       = mem_q[rd_ptr_q];
  assign blk_key    = blk_valid ? head[31:16] : '0;
  assign blk_data   = blk_valid ? head[15:0]  : '0;
  assign frame_err  = frame_err_q;

  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    kind_d       = kind_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    frame_err_d  = 1'b0;
    push         = 1'b0;
    if (accept) begin
      case (state_q)
        HI: begin
          hi_d    = byte_in;
          kind_d  = byte_is_key;
          state_d = LO;
        end
        LO: begin
          if (byte_is_key != kind_q) begin
            // Kind switch: drop the buffered half-word, restart with this byte as high.
            frame_err_d = 1'b1;
            hi_d        = byte_in;
            kind_d      = byte_is_key;
          end else begin
            state_d = HI;
            if (kind_q) begin
              key_d        = {hi_q, byte_in};
              key_loaded_d = 1'b1;
            end else if (key_loaded_q) begin
              push = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: state_d = HI;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HI;
      hi_q         <= '0;
      kind_q       <= 1'b0;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      frame_err_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      kind_q       <= kind_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      frame_err_q  <= frame_err_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: head outputs are masked by blk_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {key_q, hi_q, byte_in};
  end

`ifdef SAES_BLK_COUNT_EN
  logic [15:0] blk_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      blk_count_q <= '0;
    else if (pop) blk_count_q <= blk_count_q + 16'd1;
  end
  assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_saes_byte_loader.sv
// Directed self-checking bench for saes_byte_loader (DEPTH = 4).
module tb_saes_byte_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_is_key;
  logic        byte_valid;
  logic        byte_ready;
  logic [15:0] blk_data;
  logic [15:0] blk_key;
  logic        blk_valid;
  logic        blk_ready;
  logic        frame_err;
`ifdef SAES_BLK_COUNT_EN
  logic [15:0] blk_count;
`endif

  int unsigned passed = 0;
  int unsigned total  = 0;

  saes_byte_loader #(.DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_is_key (byte_is_key),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .blk_data    (blk_data),
    .blk_key     (blk_key),
    .blk_valid   (blk_valid),
    .blk_ready   (blk_ready),
    .frame_err   (frame_err)
`ifdef SAES_BLK_COUNT_EN
    ,
    .blk_count   (blk_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte and returns #1 after the edge that accepted it.
  task automatic send(input logic [7:0] b, input logic k);
    logic acc;
    int   n;
    byte_in     = b;
    byte_is_key = k;
    byte_valid  = 1'b1;
    n = 0;
    do begin
      acc = byte_ready;
      step();
      n++;
    end while (!acc && n < 50);
    byte_valid = 1'b0;
    if (!acc) begin
      total++;
      $display("FAIL send_timeout byte=%h byte_ready never rose", b);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_in = '0; byte_is_key = 1'b0; byte_valid = 1'b0; blk_ready = 1'b0;
    step(); step();
    total++; if (byte_ready !== 1'b1) $display("FAIL reset_byte_ready got %b exp 1", byte_ready); else passed++;
    total++; if (blk_valid !== 1'b0) $display("FAIL reset_blk_valid got %b exp 0", blk_valid); else passed++;
    total++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b exp 0", frame_err); else passed++;
    total++; if ({blk_key, blk_data} !== 32'h0) $display("FAIL reset_head got %h exp 00000000", {blk_key, blk_data}); else passed++;
`ifdef SAES_BLK_COUNT_EN
    total++; if (blk_count !== 16'h0) $display("FAIL reset_blk_count got %h exp 0000", blk_count); else passed++;
`endif
    rst = 1'b0;
    step();
  endtask

  task automatic test_data_no_key();
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    total++; if (frame_err !== 1'b1) $display("FAIL nokey_frame_err got %b exp 1", frame_err); else passed++;
    total++; if (blk_valid !== 1'b0) $display("FAIL nokey_blk_valid got %b exp 0", blk_valid); else passed++;
    step();
    total++; if (frame_err !== 1'b0) $display("FAIL nokey_err_pulse_len got %b exp 0", frame_err); else passed++;
    total++; if (blk_valid !== 1'b0) $display("FAIL nokey_blk_valid_later got %b exp 0", blk_valid); else passed++;
  endtask

  task automatic test_key_then_data();
    blk_ready = 1'b1;
    send(8'h4A, 1'b1);
    send(8'hF5, 1'b1);
    send(8'hD7, 1'b0);
    send(8'h28, 1'b0);
    total++; if (blk_valid !== 1'b1) $display("FAIL kd_blk_valid got %b exp 1", blk_valid); else passed++;
    total++; if (blk_key !== 16'h4AF5) $display("FAIL kd_blk_key got %h exp 4af5", blk_key); else passed++;
    total++; if (blk_data !== 16'hD728) $display("FAIL kd_blk_data got %h exp d728", blk_data); else passed++;
    step();
    total++; if (blk_valid !== 1'b0) $display("FAIL kd_popped got %b exp 0", blk_valid); else passed++;
    blk_ready = 1'b0;
  endtask

  task automatic test_kind_switch();
    send(8'hAB, 1'b1);
    send(8'hCD, 1'b0);
    total++; if (frame_err !== 1'b1) $display("FAIL switch_frame_err got %b exp 1", frame_err); else passed++;
    send(8'hEF, 1'b0);
    total++; if (frame_err !== 1'b0) $display("FAIL switch_err_cleared got %b exp 0", frame_err); else passed++;
    total++; if (blk_valid !== 1'b1) $display("FAIL switch_blk_valid got %b exp 1", blk_valid); else passed++;
    total++; if ({blk_key, blk_data} !== 32'h4AF5CDEF) $display("FAIL switch_head got %h exp 4af5cdef", {blk_key, blk_data}); else passed++;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    total++; if (blk_valid !== 1'b0) $display("FAIL switch_popped got %b exp 0", blk_valid); else passed++;
  endtask

  task automatic test_fill();
    logic [15:0] exp_data [4];
    exp_data[0] = 16'h1213; exp_data[1] = 16'h1415; exp_data[2] = 16'h1617; exp_data[3] = 16'h2021;
    for (int i = 0; i < 8; i++) begin
      send(8'(8'h10 + i), 1'b0);
      if (i == 5) begin
        total++; if (byte_ready !== 1'b1) $display("FAIL fill_ready_at3 got %b exp 1", byte_ready); else passed++;
      end
    end
    total++; if (byte_ready !== 1'b0) $display("FAIL fill_ready_full got %b exp 0", byte_ready); else passed++;
    byte_in = 8'h20; byte_is_key = 1'b0; byte_valid = 1'b1;
    step(); step(); step();
    total++; if (byte_ready !== 1'b0) $display("FAIL fill_held got %b exp 0", byte_ready); else passed++;
    total++; if (blk_data !== 16'h1011) $display("FAIL fill_head_held got %h exp 1011", blk_data); else passed++;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    total++; if (byte_ready !== 1'b1) $display("FAIL fill_ready_after_pop got %b exp 1", byte_ready); else passed++;
    total++; if (blk_data !== 16'h1213) $display("FAIL fill_head_after_pop got %h exp 1213", blk_data); else passed++;
    step();
    byte_valid = 1'b0;
    send(8'h21, 1'b0);
    total++; if (byte_ready !== 1'b0) $display("FAIL fill_refull got %b exp 0", byte_ready); else passed++;
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (blk_valid !== 1'b1 || blk_data !== exp_data[i] || blk_key !== 16'h4AF5)
        $display("FAIL fill_drain%0d got v=%b %h/%h exp v=1 4af5/%h", i, blk_valid, blk_key, blk_data, exp_data[i]);
      else passed++;
      step();
    end
    blk_ready = 1'b0;
    total++; if (blk_valid !== 1'b0) $display("FAIL fill_empty got %b exp 0", blk_valid); else passed++;
  endtask

  task automatic test_key_change();
    send(8'h11, 1'b1); send(8'h11, 1'b1);
    send(8'h00, 1'b0); send(8'h01, 1'b0);
    send(8'h22, 1'b1); send(8'h22, 1'b1);
    send(8'h00, 1'b0); send(8'h02, 1'b0);
    total++; if ({blk_key, blk_data} !== 32'h11110001) $display("FAIL keychg_first got %h exp 11110001", {blk_key, blk_data}); else passed++;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    total++; if ({blk_key, blk_data} !== 32'h22220002) $display("FAIL keychg_second got %h exp 22220002", {blk_key, blk_data}); else passed++;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    total++; if (blk_valid !== 1'b0) $display("FAIL keychg_empty got %b exp 0", blk_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    send(8'h00, 1'b0); send(8'hAA, 1'b0);
    send(8'h00, 1'b0); send(8'hBB, 1'b0);
    send(8'hCC, 1'b0);
    #2 rst = 1'b1;
    #1;
    total++; if (blk_valid !== 1'b0) $display("FAIL rstmid_blk_valid got %b exp 0", blk_valid); else passed++;
    total++; if ({blk_key, blk_data} !== 32'h0) $display("FAIL rstmid_head got %h exp 00000000", {blk_key, blk_data}); else passed++;
    total++; if (byte_ready !== 1'b1) $display("FAIL rstmid_byte_ready got %b exp 1", byte_ready); else passed++;
    step();
    rst = 1'b0;
    step();
    send(8'h00, 1'b1); send(8'h00, 1'b1);
    total++; if (frame_err !== 1'b0) $display("FAIL rstmid_halfword_lost got %b exp 0", frame_err); else passed++;
    send(8'h00, 1'b0); send(8'h00, 1'b0);
    total++; if (blk_valid !== 1'b1 || {blk_key, blk_data} !== 32'h0)
      $display("FAIL rstmid_block got v=%b %h exp v=1 00000000", blk_valid, {blk_key, blk_data}); else passed++;
    blk_ready = 1'b1;
    step();
    blk_ready = 1'b0;
    total++; if (blk_valid !== 1'b0) $display("FAIL rstmid_single got %b exp 0", blk_valid); else passed++;
`ifdef SAES_BLK_COUNT_EN
    total++; if (blk_count !== 16'h1) $display("FAIL rstmid_blk_count got %h exp 0001", blk_count); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_data_no_key();
    test_key_then_data();
    test_kind_switch();
    test_fill();
    test_key_change();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
